state_frame_watcher: RTL and testbench

- Parametrised successor to the single-byte UART state watcher.
- Parses framed multi-byte state commands from the UART receiver: ID byte, length byte, payload.
- Commits up to STATE_BYTES of payload into a state register when the frame targets module_id or the broadcast ID, then pulses state_change for one clock.
- One instance per controllable block: trigger, timebase, channel gain. The instance for the watcher itself is default-ON.

---
 rtl/state_frame_watcher.sv | 193 +++++++++++++++++++
 tb/tb_state_frame_watcher.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/state_frame_watcher.sv
// Framed UART state watcher: ID, length, payload -> committed state register.
// Define STATE_FRAME_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module state_frame_watcher #(
  parameter logic [7:0]                 module_id      = 8'h00,
  parameter logic [7:0]                 BCAST_ID       = 8'hFF,
  parameter int                         STATE_BYTES    = 4,
  parameter logic [8*STATE_BYTES-1:0]   DEFAULT_STATE  = '0,
  parameter int                         TIMEOUT_CYCLES = 1000000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       Rx_ready,
  input  logic [7:0]                 Rx_data,
  output logic [8*STATE_BYTES-1:0]   state,
  output logic                       state_change,
  output logic                       frame_error,
  output logic                       busy
);

  localparam int         SW  = 8 * STATE_BYTES;
  localparam int         CW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] SB8 = 8'(STATE_BYTES);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

`ifdef STATE_FRAME_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_SKIP, S_CHECK} fsm_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_LEN, S_PAYLOAD, S_SKIP} fsm_t;
`endif

  fsm_t            fsm_reg, fsm_next;
  logic            rx_ready_q;
  logic            strobe;
  logic            hit_reg, hit_next;
  logic [7:0]      len_reg, len_next;
  logic [3:0]      idx_reg, idx_next;
  logic [8:0]      rem_reg, rem_next;
  logic [CW-1:0]   tmo_reg, tmo_next;
  logic [SW-1:0]   shadow_reg, shadow_next;
  logic [SW-1:0]   state_reg, state_next;
  logic            change_reg, change_next;
  logic            error_reg, error_next;
  logic            busy_reg, busy_next;
  logic            commit, error;
`ifdef STATE_FRAME_CHECKSUM_EN
  logic [7:0]      csum_reg, csum_next;
`endif

  assign strobe = Rx_ready & ~rx_ready_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_reg    <= S_IDLE;
      rx_ready_q <= 1'b0;
      hit_reg    <= 1'b0;
      len_reg    <= '0;
      idx_reg    <= '0;
      rem_reg    <= '0;
      tmo_reg    <= '0;
      shadow_reg <= '0;
      state_reg  <= DEFAULT_STATE;
      change_reg <= 1'b0;
      error_reg  <= 1'b0;
      busy_reg   <= 1'b0;
`ifdef STATE_FRAME_CHECKSUM_EN
      csum_reg   <= '0;
`endif
    end else begin
      fsm_reg    <= fsm_next;
      rx_ready_q <= Rx_ready;
      hit_reg    <= hit_next;
      len_reg    <= len_next;
      idx_reg    <= idx_next;
      rem_reg    <= rem_next;
      tmo_reg    <= tmo_next;
      shadow_reg <= shadow_next;
      state_reg  <= state_next;
      change_reg <= change_next;
      error_reg  <= error_next;
      busy_reg   <= busy_next;
`ifdef STATE_FRAME_CHECKSUM_EN
      csum_reg   <= csum_next;
`endif
    end
  end

  // Next-state logic; an accept in the same cycle as the timeout takes priority
  always_comb begin
    fsm_next    = fsm_reg;
    hit_next    = hit_reg;
    len_next    = len_reg;
    idx_next    = idx_reg;
    rem_next    = rem_reg;
    shadow_next = shadow_reg;
    commit      = 1'b0;
    error       = 1'b0;
`ifdef STATE_FRAME_CHECKSUM_EN
    csum_next   = csum_reg;
`endif
    if (strobe) begin
      case (fsm_reg)
        S_IDLE: begin
          hit_next = (Rx_data == module_id) || (Rx_data == BCAST_ID);
          fsm_next = S_LEN;
`ifdef STATE_FRAME_CHECKSUM_EN
          csum_next = Rx_data;
`endif
        end
        S_LEN: begin
          len_next = Rx_data;
`ifdef STATE_FRAME_CHECKSUM_EN
          csum_next = csum_reg ^ Rx_data;
`endif
          if (Rx_data == 8'd0) begin
            error    = 1'b1;
            fsm_next = S_IDLE;
          end else if (hit_reg && (Rx_data > SB8)) begin
            error    = 1'b1;
            rem_next = {1'b0, Rx_data};
            fsm_next = S_SKIP;
          end else if (hit_reg) begin
            idx_next = '0;
            fsm_next = S_PAYLOAD;
          end else begin
`ifdef STATE_FRAME_CHECKSUM_EN
            rem_next = {1'b0, Rx_data} + 9'd1;
`else
            rem_next = {1'b0, Rx_data};
`endif
            fsm_next = S_SKIP;
          end
        end
        S_PAYLOAD: begin
          shadow_next[8*idx_reg +: 8] = Rx_data;
          idx_next = idx_reg + 4'd1;
`ifdef STATE_FRAME_CHECKSUM_EN
          csum_next = csum_reg ^ Rx_data;
`endif
          if (({4'b0, idx_reg} + 8'd1) == len_reg) begin
`ifdef STATE_FRAME_CHECKSUM_EN
            fsm_next = S_CHECK;
`else
            commit   = 1'b1;
            fsm_next = S_IDLE;
`endif
          end
        end
`ifdef STATE_FRAME_CHECKSUM_EN
        S_CHECK: begin
          if (Rx_data == csum_reg) commit = 1'b1;
          else                     error  = 1'b1;
          fsm_next = S_IDLE;
        end
`endif
        S_SKIP: begin
          rem_next = rem_reg - 9'd1;
          if (rem_reg == 9'd1) fsm_next = S_IDLE;
        end
        default: fsm_next = S_IDLE;
      endcase
    end else if ((fsm_reg != S_IDLE) && (tmo_reg == TMO_LAST)) begin
      error       = 1'b1;
      shadow_next = '0;
      fsm_next    = S_IDLE;
    end

    if (strobe || (fsm_reg == S_IDLE) || (fsm_next == S_IDLE)) tmo_next = '0;
    else                                                        tmo_next = tmo_reg + CW'(1);
  end

  // Output logic: registered pulses and busy flag
  always_comb begin
    change_next = commit;
    error_next  = error;
    busy_next   = (fsm_next != S_IDLE);
  end

  // Only bytes covered by the frame length are replaced on commit
  genvar gi;
  generate
    for (gi = 0; gi < STATE_BYTES; gi++) begin : g_byte
      assign state_next[8*gi +: 8] = (commit && (8'(gi) < len_reg)) ?
                                     shadow_next[8*gi +: 8] : state_reg[8*gi +: 8];
    end
  endgenerate

  assign state        = state_reg;
  assign state_change = change_reg;
  assign frame_error  = error_reg;
  assign busy         = busy_reg;

endmodule

// File: tb/tb_state_frame_watcher.sv
// Scoreboard bench for state_frame_watcher: stimulus queues expected pulses,
// a negedge monitor pops and compares them as the DUT emits them.
module tb_state_frame_watcher;
  localparam int SB  = 4;
  localparam int TMO = 100;
`ifdef STATE_FRAME_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        Rx_ready;
  logic [7:0]  Rx_data;
  logic [31:0] state;
  logic        state_change;
  logic        frame_error;
  logic        busy;

  state_frame_watcher #(
    .module_id(8'h03), .BCAST_ID(8'hFF), .STATE_BYTES(SB),
    .DEFAULT_STATE(32'h0), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .Rx_ready(Rx_ready), .Rx_data(Rx_data),
    .state(state), .state_change(state_change), .frame_error(frame_error), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_change;
    logic [31:0] st;
    int          lo;
    int          hi;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_state;
  logic [7:0]  seq[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every pulse must match the oldest queued expectation
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset && (state_change || frame_error)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse change=%0b error=%0b state=%h cyc=%0d required no pulse",
                 state_change, frame_error, state, cyc);
      end else begin
        e = exp_q.pop_front();
        if (state_change !== e.is_change || frame_error !== !e.is_change ||
            state !== e.st || cyc < e.lo || cyc > e.hi) begin
          errors++;
          $display("FAIL pulse change=%0b error=%0b state=%h cyc=%0d required change=%0b error=%0b state=%h cyc=%0d..%0d",
                   state_change, frame_error, state, cyc, e.is_change, !e.is_change, e.st, e.lo, e.hi);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic expect_ev(input bit chg, input int lo, input int hi);
    exp_t e;
    e.is_change = chg;
    e.st        = exp_state;
    e.lo        = lo;
    e.hi        = hi;
    exp_q.push_back(e);
  endtask

  // ev: 0 none, 1 state_change expected, 2 frame_error expected one cycle after accept
  task automatic send(input logic [7:0] b, input int hold, input int ev);
    @(negedge clk);
    if (ev == 1)      expect_ev(1'b1, cyc + 1, cyc + 1);
    else if (ev == 2) expect_ev(1'b0, cyc + 1, cyc + 1);
    Rx_data  = b;
    Rx_ready = 1'b1;
    repeat (hold) @(negedge clk);
    Rx_ready = 1'b0;
  endtask

  // Sends seq; checksum byte appended in the checksum build; ev applies to the final byte
  task automatic run_seq(input int ev, input bit add_ck, input logic [7:0] ck_init);
    logic [7:0] ck;
    int n;
    ck = ck_init;
    foreach (seq[i]) ck = ck ^ seq[i];
    if (add_ck && CK_EN) seq.push_back(ck);
    n = seq.size();
    for (int i = 0; i < n; i++) send(seq[i], 1, (i == n - 1) ? ev : 0);
  endtask

  task automatic idle_check(input string name);
    repeat (2) @(negedge clk);
    chk(name, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    Rx_ready = 1'b0;
    Rx_data  = 8'h00;
    exp_state = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_state", state, 32'h0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_pulses", {30'd0, state_change, frame_error}, 32'd0);

    // Full-width frame
    send(8'h03, 1, 0);
    chk("busy_after_id", {31'd0, busy}, 32'd1);
    exp_state = 32'h44332211;
    seq = '{8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
    run_seq(1, 1'b1, 8'h03);
    idle_check("busy_after_frame_a");
    chk("state_a", state, 32'h44332211);

    // Partial frame keeps upper bytes
    exp_state = 32'h4433BBAA;
    seq = '{8'h03, 8'h02, 8'hAA, 8'hBB};
    run_seq(1, 1'b1, 8'h00);
    idle_check("busy_after_frame_b");

    // Broadcast
    exp_state = 32'h4433BB5A;
    seq = '{8'hFF, 8'h01, 8'h5A};
    run_seq(1, 1'b1, 8'h00);

    // Foreign ID skipped silently, then a one-byte frame
    seq = '{8'h07, 8'h03, 8'h01, 8'h02, 8'h03};
    run_seq(0, 1'b1, 8'h00);
    exp_state = 32'h4433BB77;
    seq = '{8'h03, 8'h01, 8'h77};
    run_seq(1, 1'b1, 8'h00);
    chk("state_d", state, 32'h4433BB77);

    // Oversize length: error at len byte, then exactly 5 bytes skipped
    send(8'h03, 1, 0);
    send(8'h05, 1, 2);
    seq = '{8'h03, 8'h01, 8'h99, 8'h03, 8'h01};
    run_seq(0, 1'b0, 8'h00);
    idle_check("busy_after_oversize");
    chk("state_oversize", state, 32'h4433BB77);

    // Zero length
    send(8'h03, 1, 0);
    send(8'h00, 1, 2);
    idle_check("busy_after_len0");

    // Held Rx_ready yields a single accept
    send(8'h03, 50, 0);
    chk("busy_after_held_id", {31'd0, busy}, 32'd1);
    exp_state = 32'h4433BB5C;
    seq = '{8'h01, 8'h5C};
    run_seq(1, 1'b1, 8'h03);
    idle_check("busy_after_hold");

`ifdef STATE_FRAME_CHECKSUM_EN
    exp_state = 32'h4433BB0F;
    seq = '{8'h03, 8'h01, 8'h0F, 8'h0D};
    run_seq(1, 1'b0, 8'h00);
    seq = '{8'h03, 8'h01, 8'h0F, 8'h00};
    run_seq(2, 1'b0, 8'h00);
    idle_check("busy_after_bad_ck");
    chk("state_bad_ck", state, 32'h4433BB0F);
`endif

    // Inter-byte timeout
    send(8'h03, 1, 0);
    send(8'h02, 1, 0);
    @(negedge clk);
    expect_ev(1'b0, cyc + TMO - 1, cyc + TMO + 4);
    Rx_data  = 8'h10;
    Rx_ready = 1'b1;
    @(negedge clk);
    Rx_ready = 1'b0;
    for (int i = 0; i < TMO + 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("timeout_pulse_seen", exp_q.size(), 32'd0);
    chk("timeout_busy", {31'd0, busy}, 32'd0);
    chk("timeout_state", state, exp_state);

    // Reset mid-frame restores the default state
    send(8'h03, 1, 0);
    send(8'h04, 1, 0);
    send(8'h11, 1, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midreset_state", state, 32'h0);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_state = 32'h00000042;
    seq = '{8'h03, 8'h01, 8'h42};
    run_seq(1, 1'b1, 8'h00);
    idle_check("busy_after_recovery");

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
